// File: rtl/slot_allocator.sv
// Slot pool allocator: hands out the highest-indexed free slot each cycle and
// tracks occupancy with a busy vector and a population count.
module slot_allocator #(
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_req,
   output logic             alloc_gnt,
   output logic [N-1:0]     alloc_idx,
   input  logic             free_req,
   input  logic [N-1:0]     free_idx,
   input  logic             flush,
   output logic [2**N-1:0]  busy,
   output logic [N:0]       count,
   output logic             full,
   output logic             empty,
   output logic             free_err
);

   localparam int S = 2**N;

   logic [N-1:0] sel;
   logic [S-1:0] sel_mask;
   logic [S-1:0] free_mask;
   logic         alloc_ok;
   logic         free_ok;
   logic         free_bad;
   logic [S-1:0] busy_nxt;
   logic [N:0]   count_nxt;

   assign full  = (count == (N+1)'(S));
   assign empty = (count == '0);

   // Ascending scan: the last free slot seen is the highest-indexed one.
   always_comb begin
      sel = '0;
      for (int i = 0; i < S; i++) begin
         if (!busy[i]) sel = N'(i);
      end
   end

   assign sel_mask  = S'(1) << sel;
   assign free_mask = S'(1) << free_idx;
   assign alloc_ok  = alloc_req & ~full;
   assign free_ok   = free_req & busy[free_idx];
   assign free_bad  = free_req & ~busy[free_idx];

   // The freed slot is still busy pre-edge, so it can never equal sel here.
   always_comb begin
      busy_nxt  = busy;
      count_nxt = count;
      if (free_ok) busy_nxt = busy_nxt & ~free_mask;
      if (alloc_ok) busy_nxt = busy_nxt | sel_mask;
      count_nxt = count + (N+1)'(alloc_ok) - (N+1)'(free_ok);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy      <= '0;
         count     <= '0;
         alloc_gnt <= 1'b0;
         alloc_idx <= '0;
         free_err  <= 1'b0;
      end else if (flush) begin
         busy      <= '0;
         count     <= '0;
         alloc_gnt <= 1'b0;
         free_err  <= 1'b0;
      end else begin
         busy      <= busy_nxt;
         count     <= count_nxt;
         alloc_gnt <= alloc_ok;
         free_err  <= free_bad;
         if (alloc_ok) alloc_idx <= sel;
      end
   end

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_slot_allocator;

   localparam int N = 4;
   localparam int S = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         alloc_req = 1'b0;
   logic         free_req = 1'b0;
   logic         flush = 1'b0;
   logic [N-1:0] free_idx = '0;
   logic         alloc_gnt;
   logic [N-1:0] alloc_idx;
   logic [S-1:0] busy;
   logic [N:0]   count;
   logic         full;
   logic         empty;
   logic         free_err;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   slot_allocator #(.N(N)) dut (
      .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
      .alloc_idx(alloc_idx), .free_req(free_req), .free_idx(free_idx),
      .flush(flush), .busy(busy), .count(count), .full(full),
      .empty(empty), .free_err(free_err)
   );

   // Reference model: one bit per slot, outputs derived by plain loops.
   bit m_slot[S];
   int m_idx = 0;
   bit m_gnt = 0;
   bit m_err = 0;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < S; i++) c += int'(m_slot[i]);
      return c;
   endfunction

   function automatic logic [S-1:0] m_vec();
      logic [S-1:0] v = '0;
      for (int i = 0; i < S; i++) v[i] = m_slot[i];
      return v;
   endfunction

   task automatic model_step(input bit r, input bit a, input bit f,
                             input bit fl, input int fi);
      int pick = -1;
      bit take;
      if (!r) begin
         for (int i = 0; i < S; i++) m_slot[i] = 0;
         m_gnt = 0; m_idx = 0; m_err = 0;
      end else if (fl) begin
         for (int i = 0; i < S; i++) m_slot[i] = 0;
         m_gnt = 0; m_err = 0;
      end else begin
         for (int i = S - 1; i >= 0; i--) begin
            if (!m_slot[i]) begin pick = i; break; end
         end
         take = a && (m_count() < S);
         m_err = f && !m_slot[fi];
         m_gnt = take;
         if (take) m_idx = pick;
         if (f && m_slot[fi]) m_slot[fi] = 0;
         if (take) m_slot[pick] = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; alloc_req = 1'b0; free_req = 1'b0; flush = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (busy !== '0 || count !== '0 || alloc_gnt !== 1'b0 || alloc_idx !== '0
          || free_err !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: busy=%h count=%0d gnt=%b idx=%0d err=%b empty=%b full=%b, want 0 0 0 0 0 1 0",
                  busy, count, alloc_gnt, alloc_idx, free_err, empty, full);
      end
   endtask

   task automatic test_fill();
      do_reset();
      alloc_req = 1'b1;
      for (int k = 0; k < S; k++) begin
         tick();
         n_checks++;
         if (alloc_gnt !== 1'b1 || alloc_idx !== N'(S - 1 - k)) begin
            n_fail++;
            $display("FAIL fill_grant[%0d]: gnt=%b idx=%0d, want 1 %0d",
                     k, alloc_gnt, alloc_idx, S - 1 - k);
         end
      end
      n_checks++;
      if (count !== 5'd16 || full !== 1'b1 || busy !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL fill_full: count=%0d full=%b busy=%h, want 16 1 ffff", count, full, busy);
      end
      tick();
      n_checks++;
      if (alloc_gnt !== 1'b0 || alloc_idx !== 4'd0 || count !== 5'd16) begin
         n_fail++;
         $display("FAIL fill_refused: gnt=%b idx=%0d count=%0d, want 0 0 16", alloc_gnt, alloc_idx, count);
      end
      alloc_req = 1'b0;
   endtask

   task automatic test_full_free_alloc();
      alloc_req = 1'b1; free_req = 1'b1; free_idx = 4'd5;
      tick();
      n_checks++;
      if (alloc_gnt !== 1'b0 || busy[5] !== 1'b0 || count !== 5'd15 || free_err !== 1'b0) begin
         n_fail++;
         $display("FAIL full_free: gnt=%b busy5=%b count=%0d err=%b, want 0 0 15 0",
                  alloc_gnt, busy[5], count, free_err);
      end
      free_req = 1'b0;
      tick();
      n_checks++;
      if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd5 || count !== 5'd16) begin
         n_fail++;
         $display("FAIL refill_5: gnt=%b idx=%0d count=%0d, want 1 5 16", alloc_gnt, alloc_idx, count);
      end
      alloc_req = 1'b0;
   endtask

   task automatic test_alloc_free_same();
      do_reset();
      alloc_req = 1'b1;
      repeat (3) tick();
      free_req = 1'b1; free_idx = 4'd14;
      tick();
      n_checks++;
      if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd12 || busy !== 16'hB000 || count !== 5'd3) begin
         n_fail++;
         $display("FAIL alloc_free_same: gnt=%b idx=%0d busy=%h count=%0d, want 1 12 b000 3",
                  alloc_gnt, alloc_idx, busy, count);
      end
      alloc_req = 1'b0; free_req = 1'b0;
   endtask

   task automatic test_free_err();
      do_reset();
      free_req = 1'b1; free_idx = 4'd7;
      tick();
      n_checks++;
      if (free_err !== 1'b1 || busy !== '0 || count !== '0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL free_err: err=%b busy=%h count=%0d empty=%b, want 1 0 0 1",
                  free_err, busy, count, empty);
      end
      free_req = 1'b0;
      tick();
      n_checks++;
      if (free_err !== 1'b0) begin
         n_fail++;
         $display("FAIL free_err_pulse: err=%b, want 0", free_err);
      end
   endtask

   task automatic test_flush();
      do_reset();
      alloc_req = 1'b1;
      repeat (8) tick();
      n_checks++;
      if (count !== 5'd8 || busy !== 16'hFF00) begin
         n_fail++;
         $display("FAIL pre_flush: count=%0d busy=%h, want 8 ff00", count, busy);
      end
      flush = 1'b1;
      tick();
      n_checks++;
      if (busy !== '0 || count !== '0 || alloc_gnt !== 1'b0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL flush: busy=%h count=%0d gnt=%b empty=%b, want 0 0 0 1",
                  busy, count, alloc_gnt, empty);
      end
      flush = 1'b0; alloc_req = 1'b0;
   endtask

   task automatic test_reset_inflight();
      alloc_req = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (alloc_gnt !== 1'b0 || busy !== '0 || alloc_idx !== '0 || count !== '0) begin
         n_fail++;
         $display("FAIL reset_inflight: gnt=%b busy=%h idx=%0d count=%0d, want 0 0 0 0",
                  alloc_gnt, busy, alloc_idx, count);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd15 || count !== 5'd1) begin
         n_fail++;
         $display("FAIL resume: gnt=%b idx=%0d count=%0d, want 1 15 1", alloc_gnt, alloc_idx, count);
      end
      alloc_req = 1'b0;
   endtask

   task automatic test_random();
      bit r, a, f, fl;
      int fi;
      do_reset();
      model_step(0, 0, 0, 0, 0);
      for (int c = 0; c < 400; c++) begin
         r  = ($urandom_range(0, 59) != 0);
         fl = ($urandom_range(0, 39) == 0);
         a  = ($urandom_range(0, 99) < 55);
         f  = ($urandom_range(0, 99) < 45);
         fi = $urandom_range(0, S - 1);
         rst = r; flush = fl; alloc_req = a; free_req = f; free_idx = N'(fi);
         model_step(r, a, f, fl, fi);
         tick();
         n_checks++;
         if (busy !== m_vec() || count !== (N+1)'(m_count()) || alloc_gnt !== m_gnt
             || alloc_idx !== N'(m_idx) || free_err !== m_err
             || full !== (m_count() == S) || empty !== (m_count() == 0)) begin
            n_fail++;
            $display("FAIL random[%0d]: busy=%h cnt=%0d gnt=%b idx=%0d err=%b full=%b empty=%b, want %h %0d %b %0d %b %b %b",
                     c, busy, count, alloc_gnt, alloc_idx, free_err, full, empty,
                     m_vec(), m_count(), m_gnt, m_idx, m_err, m_count() == S, m_count() == 0);
         end
      end
      rst = 1'b1; flush = 1'b0; alloc_req = 1'b0; free_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_free_alloc();
      test_alloc_free_same();
      test_free_err();
      test_flush();
      test_reset_inflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
REQ-001 SHALL have parameter N, default 4, meaning the index width; the pool holds 2**N slots.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port alloc_req  input  1  requests one free slot this cycle.
REQ-005 SHALL have port alloc_gnt  output  1  registered grant pulse, one cycle after an accepted alloc_req.
REQ-006 SHALL have port alloc_idx  output  N  encoded index of the granted slot, meaningful while alloc_gnt=1.
REQ-007 SHALL have port free_req  input  1  requests release of the slot at free_idx.
REQ-008 SHALL have port free_idx  input  N  encoded index of the slot to release.
REQ-009 SHALL have port flush  input  1  releases all slots.
REQ-010 SHALL have port busy  output  2**N  occupancy vector; bit i=1 means slot i is allocated.
REQ-011 SHALL have port count  output  N+1  number of allocated slots.
REQ-012 SHALL have port full  output  1  1 when all slots are allocated.
REQ-013 SHALL have port empty  output  1  1 when no slot is allocated.
REQ-014 SHALL have port free_err  output  1  registered pulse flagging a release of a slot that is not allocated.

Function
REQ-015 SHALL hold busy and count in registers; full, empty are combinational from registered count (full: count==2**N, empty: count==0).
REQ-016 SHALL select, for allocation, the highest-indexed slot i with busy[i]=0, evaluated on pre-edge busy.
REQ-017 SHALL accept alloc_req at an edge only if full=0; on accept: busy[sel]<=1, alloc_gnt<=1, alloc_idx<=sel.
REQ-018 SHALL, on alloc_req with full=1 or alloc_req=0, drive alloc_gnt<=0 and hold alloc_idx unchanged; a refused request is dropped, not queued.
REQ-019 SHALL decode free_idx to a one-hot mask; free_req with busy[free_idx]=1 clears that bit at the edge, free_err<=0.
REQ-020 SHALL, on free_req with busy[free_idx]=0, leave busy and count unchanged and set free_err<=1 for one cycle.
REQ-021 SHALL, with alloc and free in the same cycle, apply both: the freed slot is not allocatable that cycle (selection uses pre-edge busy); count nets to unchanged.
REQ-022 SHALL, with full=1 and simultaneous alloc_req and valid free_req, refuse the allocation and perform the release (count becomes 2**N-1).
REQ-023 SHALL update count by +1 per accepted alloc and -1 per valid free, never wrapping; count always equals popcount(busy).
REQ-024 SHALL, on flush=1, clear busy and count to 0, drive alloc_gnt<=0, free_err<=0, ignoring alloc_req and free_req that cycle.
REQ-025 SHALL sustain one allocation per cycle back-to-back while not full.

Reset
REQ-026 SHALL, on rst=0 at an edge, set busy=0, count=0, alloc_gnt=0, alloc_idx=0, free_err=0, hence empty=1, full=0.
REQ-027 SHALL give rst priority over flush, alloc_req and free_req; a grant in flight at reset is discarded.
REQ-028 SHALL resume normal operation on the first edge with rst=1.

Verification
REQ-029 SHALL cover reset then alloc_req held 16 cycles -> alloc_idx 15,14,...,0 on consecutive cycles, count 16, full=1; 17th request -> alloc_gnt=0.
REQ-030 SHALL cover full pool, free_idx=5 plus alloc_req same cycle -> no grant, busy[5]=0, count 15; next alloc_req -> alloc_idx=5.
REQ-031 SHALL cover count=3 (slots 15,14,13), alloc_req plus free_idx=14 same cycle -> grant alloc_idx=12, busy[14]=0, count stays 3.
REQ-032 SHALL cover empty pool, free_req free_idx=7 -> free_err=1 one cycle, busy=0, count=0.
REQ-033 SHALL cover 8 slots allocated, flush with alloc_req=1 -> busy=0, count=0, alloc_gnt=0, empty=1.
REQ-034 SHALL cover rst=0 asserted the same cycle as alloc_req -> next cycle alloc_gnt=0, busy=0, alloc_idx=0.
